// File: rtl/sram_serial_io_ctrl.sv
// -----------------------------------------------------------------------------
// sram_serial_io_ctrl
//   Bit-serial loader/reader for the 512x8 instruction/data SRAM. The host
//   shifts a 17-bit frame {addr[8:0], data[7:0]} in on SI, LSB first. The block
//   then performs one SRAM write, or one read whose byte is sent back on SO,
//   LSB first. It sits between the off-chip scan/test port and the SRAM.
//
// Ports
//   CLK     in   1  clock, all state on rising edge
//   RST_N   in   1  asynchronous active-low reset
//   BGN     in   1  high = run one transaction, low = abort / return to IDLE
//   SI      in   1  serial frame input (data[0] first, addr[8] last)
//   LOAD_N  in   1  0 = load mode (block owns the SRAM), 1 = block disabled
//   CTRL    in   2  00 write, 01 read, 1x no-op (shift only)
//   PI      in   8  SRAM read data (registered inside the SRAM)
//   RDY     out  1  transaction complete, held until BGN falls
//   D_WE    out  1  SRAM write enable, one-cycle pulse
//   CEN     out  1  SRAM enable, registered (RST_N & ~LOAD_N)
//   SO      out  1  serial read data, LSB first
//   A       out  9  SRAM address
//   PO      out  8  SRAM write data
// -----------------------------------------------------------------------------
module sram_serial_io_ctrl #(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 9
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         BGN,
  input  logic                         SI,
  input  logic                         LOAD_N,
  input  logic [1:0]                   CTRL,
  input  logic [MEMORY_DATA_WIDTH-1:0] PI,
  output logic                         RDY,
  output logic                         D_WE,
  output logic                         CEN,
  output logic                         SO,
  output logic [MEMORY_ADDR_WIDTH-1:0] A,
  output logic [MEMORY_DATA_WIDTH-1:0] PO
);

  localparam int REG_BITS_WIDTH = MEMORY_ADDR_WIDTH + MEMORY_DATA_WIDTH;
  localparam int CNT_W          = $clog2(REG_BITS_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_WRITE,
    S_RDADDR,
    S_RDCAP,
    S_SHOUT,
    S_DONE
  } state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [REG_BITS_WIDTH-1:0]      sreg_q, sreg_d;
  logic [MEMORY_DATA_WIDTH-1:0]   oreg_q, oreg_d;
  logic [MEMORY_ADDR_WIDTH-1:0]   a_q, a_d;
  logic [MEMORY_DATA_WIDTH-1:0]   po_q, po_d;
  logic                           we_q, we_d;
  logic                           rdy_q, rdy_d;
  logic                           so_q, so_d;
  logic                           cen_q;

  // Frame contents including the bit being sampled on this edge, so the
  // address/data can be loaded into A/PO on the same edge the 17th bit lands.
  logic [REG_BITS_WIDTH-1:0]      shift_next;
  assign shift_next = {SI, sreg_q[REG_BITS_WIDTH-1:1]};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      oreg_q  <= '0;
      a_q     <= '0;
      po_q    <= '0;
      we_q    <= 1'b0;
      rdy_q   <= 1'b0;
      so_q    <= 1'b0;
      cen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      oreg_q  <= oreg_d;
      a_q     <= a_d;
      po_q    <= po_d;
      we_q    <= we_d;
      rdy_q   <= rdy_d;
      so_q    <= so_d;
      cen_q   <= ~LOAD_N;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    oreg_d  = oreg_q;
    a_d     = a_q;
    po_d    = po_q;
    so_d    = so_q;
    we_d    = 1'b0;
    rdy_d   = 1'b0;

    // Disabling the block or dropping BGN mid-transaction always wins; an
    // aborted frame never reaches WRITE, so no partial write can happen.
    if (LOAD_N || (!BGN && (state_q != S_IDLE))) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (BGN) state_d = S_SETUP;
        end
        // Dead cycle: the host presents frame bit 0 after this edge.
        S_SETUP: begin
          state_d = S_SHIFT;
        end
        S_SHIFT: begin
          sreg_d = shift_next;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(REG_BITS_WIDTH - 1)) begin
            cnt_d = '0;
            unique case (CTRL)
              2'b00: begin
                state_d = S_WRITE;
                a_d     = shift_next[REG_BITS_WIDTH-1:MEMORY_DATA_WIDTH];
                po_d    = shift_next[MEMORY_DATA_WIDTH-1:0];
                we_d    = 1'b1;
              end
              2'b01: begin
                state_d = S_RDADDR;
                a_d     = shift_next[REG_BITS_WIDTH-1:MEMORY_DATA_WIDTH];
              end
              default: begin
                state_d = S_DONE;
                rdy_d   = 1'b1;
              end
            endcase
          end
        end
        S_WRITE: begin
          state_d = S_DONE;
          rdy_d   = 1'b1;
        end
        // SRAM read is registered: PI is valid one cycle after A.
        S_RDADDR: begin
          state_d = S_RDCAP;
        end
        // Bit 0 goes straight to SO; the rest waits in oreg, pre-shifted.
        S_RDCAP: begin
          so_d    = PI[0];
          oreg_d  = {1'b0, PI[MEMORY_DATA_WIDTH-1:1]};
          cnt_d   = '0;
          state_d = S_SHOUT;
        end
        S_SHOUT: begin
          so_d   = oreg_q[0];
          oreg_d = {1'b0, oreg_q[MEMORY_DATA_WIDTH-1:1]};
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MEMORY_DATA_WIDTH - 2)) begin
            cnt_d   = '0;
            state_d = S_DONE;
            rdy_d   = 1'b1;
          end
        end
        // Hold until BGN falls (handled above); no re-trigger while high.
        S_DONE: begin
          rdy_d = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign RDY  = rdy_q;
  assign D_WE = we_q;
  assign CEN  = cen_q;
  assign SO   = so_q;
  assign A    = a_q;
  assign PO   = po_q;

endmodule

// File: tb/tb_sram_serial_io_ctrl.sv
// Directed bench for sram_serial_io_ctrl with a behavioural 512x8 SRAM
// (registered read, write on edge when D_WE) attached to the A/PO/PI bus.
module tb_sram_serial_io_ctrl;

  logic       CLK;
  logic       RST_N;
  logic       BGN;
  logic       SI;
  logic       LOAD_N;
  logic [1:0] CTRL;
  logic [7:0] PI;
  logic       RDY;
  logic       D_WE;
  logic       CEN;
  logic       SO;
  logic [8:0] A;
  logic [7:0] PO;

  sram_serial_io_ctrl dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .BGN    (BGN),
    .SI     (SI),
    .LOAD_N (LOAD_N),
    .CTRL   (CTRL),
    .PI     (PI),
    .RDY    (RDY),
    .D_WE   (D_WE),
    .CEN    (CEN),
    .SO     (SO),
    .A      (A),
    .PO     (PO)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Behavioural SRAM
  logic [7:0] mem [512];
  always @(posedge CLK) begin
    if (CEN && D_WE) mem[A] <= PO;
    if (CEN) PI <= mem[A];
  end

  int we_count = 0;
  always @(posedge CLK) if (D_WE === 1'b1) we_count++;

  int n_pass  = 0;
  int n_check = 0;
  logic [7:0] bytes14 [14];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_check++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full write transaction: checks the pulse, bus values and RDY latency (20 edges).
  task automatic do_write(input logic [8:0] addr, input logic [7:0] data);
    logic [16:0] frame;
    int we0;
    frame = {addr, data};
    we0   = we_count;
    CTRL  = 2'b00;
    BGN   = 1'b1;
    tick(); tick();
    for (int i = 0; i < 17; i++) begin
      SI = frame[i];
      tick();
    end
    check("wr_we_pulse", D_WE, 1);
    check("wr_addr", A, addr);
    check("wr_data", PO, data);
    check("wr_rdy_early", RDY, 0);
    tick();
    check("wr_rdy_edge20", RDY, 1);
    check("wr_we_low", D_WE, 0);
    check("wr_we_count", we_count - we0, 1);
    BGN = 1'b0;
    tick();
    check("wr_rdy_clear", RDY, 0);
    $display("write addr=%03h data=%02h", addr, data);
  endtask

  // Full read transaction: assembles the SO stream, checks RDY at edge 28.
  task automatic do_read(input logic [8:0] addr, input logic [7:0] exp);
    logic [16:0] frame;
    logic [7:0]  so_byte;
    logic        rdy_pre;
    int          we0;
    frame = {addr, 8'h00};
    we0   = we_count;
    CTRL  = 2'b01;
    BGN   = 1'b1;
    rdy_pre = 1'b0;
    tick(); tick();
    for (int i = 0; i < 17; i++) begin
      SI = frame[i];
      tick();
    end
    check("rd_addr", A, addr);
    check("rd_we_low", D_WE, 0);
    tick(); tick();
    so_byte[0] = SO;
    for (int k = 1; k < 8; k++) begin
      if (k == 7) rdy_pre = RDY;
      tick();
      so_byte[k] = SO;
    end
    check("rd_rdy_early", rdy_pre, 0);
    check("rd_rdy_edge28", RDY, 1);
    check("rd_so_byte", so_byte, exp);
    check("rd_no_write", we_count - we0, 0);
    BGN = 1'b0;
    tick();
    check("rd_rdy_clear", RDY, 0);
    $display("read  addr=%03h so=%02h exp=%02h", addr, so_byte, exp);
  endtask

  initial begin
    int we0;
    logic [16:0] frame;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    for (int i = 0; i < 14; i++) bytes14[i] = 8'(8'h04 + i * 8'h13);
    RST_N  = 1'b0;
    BGN    = 1'b0;
    SI     = 1'b0;
    LOAD_N = 1'b0;
    CTRL   = 2'b00;
    #1;
    check("rst_rdy", RDY, 0);
    check("rst_we", D_WE, 0);
    check("rst_cen", CEN, 0);
    check("rst_so", SO, 0);
    check("rst_a", A, 0);
    check("rst_po", PO, 0);
    tick(); tick();
    RST_N = 1'b1;
    tick();
    check("cen_load_mode", CEN, 1);

    // Single write 0x04 at 0x020
    do_write(9'h020, 8'h04);
    check("mem_020", mem[9'h020], 8'h04);

    // Reset in the middle of a shift
    we0   = we_count;
    frame = {9'h0F0, 8'hEE};
    CTRL  = 2'b00;
    BGN   = 1'b1;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      SI = frame[i];
      tick();
    end
    RST_N = 1'b0;
    #1;
    check("midrst_rdy", RDY, 0);
    check("midrst_we", D_WE, 0);
    check("midrst_cen", CEN, 0);
    check("midrst_so", SO, 0);
    check("midrst_a", A, 0);
    check("midrst_po", PO, 0);
    BGN = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();
    check("midrst_no_write", we_count - we0, 0);
    check("midrst_mem", mem[9'h0F0], 8'h00);
    $display("reset mid-shift done");

    // Bulk load and readback
    for (int i = 0; i < 14; i++) do_write(9'(9'h020 + i), bytes14[i]);
    do_write(9'h000, 8'hAB);
    do_write(9'h001, 8'h00);
    do_write(9'h002, 8'h00);
    do_write(9'h003, 8'h3C);
    for (int i = 0; i < 14; i++) do_read(9'(9'h020 + i), bytes14[i]);
    do_read(9'h000, 8'hAB);
    do_read(9'h001, 8'h00);
    do_read(9'h002, 8'h00);
    do_read(9'h003, 8'h3C);

    // Top address: SO = 0,1,0,1,1,0,1,0
    do_write(9'h1FF, 8'h5A);
    do_read(9'h1FF, 8'h5A);

    // Abort a write frame after 10 bits
    we0   = we_count;
    frame = {9'h030, 8'hFF};
    CTRL  = 2'b00;
    BGN   = 1'b1;
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      SI = frame[i];
      tick();
    end
    BGN = 1'b0;
    for (int i = 0; i < 12; i++) begin
      SI = 1'b1;
      tick();
    end
    check("abort_rdy", RDY, 0);
    check("abort_no_we", we_count - we0, 0);
    check("abort_mem", mem[9'h030], 8'h00);
    $display("abort after 10 bits done");
    do_read(9'h030, 8'h00);

    // Block disabled: BGN ignored
    we0    = we_count;
    LOAD_N = 1'b1;
    tick();
    check("dis_cen", CEN, 0);
    BGN = 1'b1;
    CTRL = 2'b00;
    for (int i = 0; i < 25; i++) begin
      SI = 1'b1;
      tick();
    end
    check("dis_rdy", RDY, 0);
    check("dis_no_we", we_count - we0, 0);
    BGN    = 1'b0;
    LOAD_N = 1'b0;
    tick();
    check("dis_cen_back", CEN, 1);
    $display("disabled pulse done");

    // No-op frame: RDY after 19 edges, held while BGN high
    we0   = we_count;
    frame = {9'h040, 8'h77};
    CTRL  = 2'b10;
    BGN   = 1'b1;
    tick(); tick();
    for (int i = 0; i < 16; i++) begin
      SI = frame[i];
      tick();
    end
    check("noop_rdy_edge18", RDY, 0);
    SI = frame[16];
    tick();
    check("noop_rdy_edge19", RDY, 1);
    tick(); tick(); tick();
    check("noop_rdy_hold", RDY, 1);
    check("noop_no_we", we_count - we0, 0);
    check("noop_mem", mem[9'h040], 8'h00);
    BGN = 1'b0;
    tick();
    check("noop_rdy_clear", RDY, 0);
    $display("noop frame done");

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
